sha_schedule: RTL and testbench
===============================

// Module: sha_schedule
// PURPOSE
//  Message-schedule stage feeding sha_mainloop with one (W_t, K_t) pair per round.
//  Accepts one 16-word message block, one word per handshake.
//  Expands the block on the fly through a 16-entry circular buffer and emits W_t/K_t
//  for t = 0..63 (SHA-224/256) or t = 0..79 (SHA-384/512/512_224/512_256).
//  Downstream drives mainloop enable from w_valid; mainloop never stalls.
// PARAMETERS
//  WORD_W   64  datapath width; 32-bit modes use bits [31:0], bits [63:32] driven 0
//  ROUND_W  7   width of round index (covers 0..79)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         asynchronous, active-high reset
//  mode       in   sha::mode_t  algorithm select; sampled only on accepted start
//  start      in   1         begin new block; accepted only in IDLE
//  din_valid  in   1         message word valid
//  din_ready  out  1         stage accepts message word (1 only in LOAD)
//  din        in   WORD_W    message word, big-endian word order, W0 first
//  w_valid    out  1         w/k/round valid this cycle (= mainloop enable)
//  w          out  WORD_W    schedule word W_t
//  k          out  WORD_W    round constant K_t
//  round      out  ROUND_W   t of current w/k
//  last       out  1         w_valid beat is final round (63 or 79)
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; w_valid, w, k, round, last, busy, din_ready = 0; buffer cleared.
//  States:
//   IDLE: start=1 and mode!=sha1 -> latch mode, cnt=0, go to LOAD.
//     start with mode=sha1 is ignored; stay IDLE.
//   LOAD: din_ready=1; on din_valid&din_ready, buf[cnt[3:0]]<=din (upper 32b masked in 32-bit modes).
//     On acceptance: next cycle w_valid=1, w=din, k=K[cnt], round=cnt; cnt++.
//     No acceptance -> w_valid=0 next cycle.
//     Accepting cnt=15 -> RUN.
//   RUN: din_ready=0; every cycle emit W_t, t=cnt, and write it back to buf[t mod 16]; cnt++.
//     Final round (63 / 79): last=1 with that beat, then IDLE.
//  Latency: word accepted in cycle n -> appears on w in cycle n+1.
//    RUN has one word per cycle, no bubbles.
//    Block total = 16 accepts + (48|64) cycles.
//  Expansion (t>=16), mod 2^32 or 2^64 per mode:
//    W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}
//    Buffer index = (t-k) mod 16.
//   32-bit: s0 = ROTR7^ROTR18^SHR3;  s1 = ROTR17^ROTR19^SHR10
//   64-bit: s0 = ROTR1^ROTR8^SHR7;   s1 = ROTR19^ROTR61^SHR6
//  K: combinational ROM (64x32 FIPS 180-4 K256, 80x64 K512) indexed by cnt, registered with w.
//    224 uses K256; all 512 variants use K512.
//  Outputs w, k, round are registered.
//    They hold their last value while w_valid=0.
//    last=0 whenever w_valid=0.
//  start while busy: ignored. mode changes while busy: ignored (latched copy used).
//  rst mid-block: immediate return to IDLE.
//    Partial block discarded; next block needs a fresh start.
//  cnt counter is ROUND_W bits, never wraps: terminal value per mode ends RUN.
// TESTING
//  T1 SHA-256 "abc" padded block.
//    W0=0x61626380, W1..W14=0, W15=0x18, din_valid held 1.
//    Required: beats t=0..63 consecutive after first accept-cycle+1.
//    W16=0x61626380, W17=0x000F0000, K0=0x428A2F98, K63=0xC67178F2, last only at t=63.
//  T2 SHA-512 "abc".
//    W0=0x6162638000000000, W15=0x18.
//    Required: 80 beats, W16=0x6162638000000000, K0=0x428A2F98D728AE22.
//    K79=0x6C44198C4A475817, last at t=79.
//  T3 LOAD stalls: din_valid toggled 1/0 every cycle.
//    Required: w_valid gaps mirror stalls, round increments only on beats.
//    RUN output identical to T1.
//  T4 start with mode=sha1 -> busy stays 0, din_ready 0.
//    start asserted mid-RUN (sha256) -> ignored, round sequence uninterrupted.
//  T5 rst asserted at t=30 of a SHA-256 block -> all outputs 0 same cycle.
//    New start + T1 block gives exact T1 results.
//  T6 back-to-back: start in cycle after last.
//    SHA-224 block then SHA-384 block.
//    Required: 64 then 80 beats, 32-bit words upper half 0.
//    Second block expansion independent of first buffer contents.

Source files
------------

// File: rtl/sha_schedule.sv
// ---------------------------------------------------------------------------
// sha_schedule -- SHA-2 message-schedule stage.
//
// Takes one 16-word message block, one word per din handshake. It then emits
// one (W_t, K_t) pair per cycle for the main compression loop:
//   t = 0..63 for SHA-224/256
//   t = 0..79 for SHA-384/512/512_224/512_256
// Words W16 and later are expanded on the fly in a 16-entry circular buffer.
// Each new word overwrites the slot of W_{t-16}, which is no longer needed.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   mode             algorithm select, latched when a start is accepted
//   start            begin a new block (honoured only when idle)
//   din_valid/ready  message word handshake (ready only while loading)
//   din              message word, W0 first
//   w_valid          w/k/round valid this cycle (drives mainloop enable)
//   w, k, round      schedule word, round constant and round index
//   last             final round of the block (63 or 79)
//   busy             block in progress
//
// In 32-bit modes only bits [31:0] carry data; bits [63:32] are driven 0.
// ---------------------------------------------------------------------------
package sha;
    typedef enum logic [2:0] {
        SHA1       = 3'd0,
        SHA224     = 3'd1,
        SHA256     = 3'd2,
        SHA384     = 3'd3,
        SHA512     = 3'd4,
        SHA512_224 = 3'd5,
        SHA512_256 = 3'd6
    } mode_t;
endpackage

module sha_schedule #(
    parameter int WORD_W  = 64,   // datapath is built for 64 bits
    parameter int ROUND_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  sha::mode_t         mode,
    input  logic               start,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [WORD_W-1:0]  din,
    output logic               w_valid,
    output logic [WORD_W-1:0]  w,
    output logic [WORD_W-1:0]  k,
    output logic [ROUND_W-1:0] round,
    output logic               last,
    output logic               busy
);
    import sha::*;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    // K512 constants. The 32-bit K256 table equals the upper half of the
    // first 64 entries, so only one table is stored.
    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    state_t             state_reg;
    mode_t              mode_reg;
    logic [ROUND_W-1:0] cnt_reg;
    logic [WORD_W-1:0]  sched_buf_reg [16];
    logic               w_valid_reg, last_reg, busy_reg, din_ready_reg;
    logic [WORD_W-1:0]  w_reg, k_reg;
    logic [ROUND_W-1:0] round_reg;

    logic               is64;
    logic [ROUND_W-1:0] term;
    logic [63:0]        w_m2, w_m7, w_m15, w_m16;
    logic [63:0]        s0_64, s1_64, sum_64;
    logic [31:0]        s0_32, s1_32, sum_32;
    logic [63:0]        w_next, din_m, k_rom, k_next;

    assign is64 = (mode_reg == SHA384) || (mode_reg == SHA512) ||
                  (mode_reg == SHA512_224) || (mode_reg == SHA512_256);
    assign term = is64 ? ROUND_W'(79) : ROUND_W'(63);

    // Buffer taps: slot (t-n) mod 16; the 4-bit sum wraps naturally.
    assign w_m2  = sched_buf_reg[cnt_reg[3:0] + 4'd14];
    assign w_m7  = sched_buf_reg[cnt_reg[3:0] + 4'd9];
    assign w_m15 = sched_buf_reg[cnt_reg[3:0] + 4'd1];
    assign w_m16 = sched_buf_reg[cnt_reg[3:0]];

    assign s0_64  = {w_m15[0], w_m15[63:1]} ^ {w_m15[7:0], w_m15[63:8]} ^ (w_m15 >> 7);
    assign s1_64  = {w_m2[18:0], w_m2[63:19]} ^ {w_m2[60:0], w_m2[63:61]} ^ (w_m2 >> 6);
    assign sum_64 = s1_64 + w_m7 + s0_64 + w_m16;

    assign s0_32  = {w_m15[6:0], w_m15[31:7]} ^ {w_m15[17:0], w_m15[31:18]} ^ (w_m15[31:0] >> 3);
    assign s1_32  = {w_m2[16:0], w_m2[31:17]} ^ {w_m2[18:0], w_m2[31:19]} ^ (w_m2[31:0] >> 10);
    assign sum_32 = s1_32 + w_m7[31:0] + s0_32 + w_m16[31:0];

    assign w_next = is64 ? sum_64 : {32'h0, sum_32};
    assign din_m  = is64 ? din : {32'h0, din[31:0]};
    assign k_rom  = K512[cnt_reg];
    assign k_next = is64 ? k_rom : {32'h0, k_rom[63:32]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= SHA256;
            cnt_reg       <= '0;
            w_valid_reg   <= 1'b0;
            w_reg         <= '0;
            k_reg         <= '0;
            round_reg     <= '0;
            last_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            din_ready_reg <= 1'b0;
            for (int i = 0; i < 16; i++) sched_buf_reg[i] <= '0;
        end else begin
            // w/k/round hold their value; valid and last are one-cycle pulses.
            w_valid_reg <= 1'b0;
            last_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && mode != SHA1) begin
                        mode_reg      <= mode;
                        cnt_reg       <= '0;
                        state_reg     <= LOAD;
                        busy_reg      <= 1'b1;
                        din_ready_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (din_valid) begin
                        sched_buf_reg[cnt_reg[3:0]] <= din_m;
                        w_reg       <= din_m;
                        k_reg       <= k_next;
                        round_reg   <= cnt_reg;
                        w_valid_reg <= 1'b1;
                        cnt_reg     <= cnt_reg + ROUND_W'(1);
                        if (cnt_reg == ROUND_W'(15)) begin
                            state_reg     <= RUN;
                            din_ready_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    sched_buf_reg[cnt_reg[3:0]] <= w_next;
                    w_reg       <= w_next;
                    k_reg       <= k_next;
                    round_reg   <= cnt_reg;
                    w_valid_reg <= 1'b1;
                    if (cnt_reg == term) begin
                        last_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;   // keeps the ROM index in range while idle
                    end else begin
                        cnt_reg <= cnt_reg + ROUND_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign din_ready = din_ready_reg;
    assign w_valid   = w_valid_reg;
    assign w         = w_reg;
    assign k         = k_reg;
    assign round     = round_reg;
    assign last      = last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_sha_schedule.sv
// Testbench for sha_schedule: table of block cases plus hand-written
// sequences (illegal start, start during RUN, reset mid-block, back-to-back).
module tb_sha_schedule;
    import sha::*;

    logic        clk = 1'b0;
    logic        rst, start, din_valid, din_ready, w_valid, last, busy;
    mode_t       mode;
    logic [63:0] din, w, k;
    logic [6:0]  round;

    always #5 clk = ~clk;

    sha_schedule dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .w_valid(w_valid), .w(w), .k(k), .round(round),
        .last(last), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard entries, pushed when a block is started.
    typedef struct {
        logic [63:0] w;
        logic [6:0]  round;
        logic        last;
        bit          kchk;
        logic [63:0] k;
    } exp_t;
    exp_t exp_q[$];

    // Known FIPS 180-4 K512 values; K256 is the upper half.
    typedef struct { int idx; logic [63:0] k; } kref_t;
    kref_t kref [6] = '{
        '{0,  64'h428a2f98d728ae22}, '{1,  64'h7137449123ef65cd},
        '{15, 64'hc19bf174cf692694}, '{16, 64'he49b69c19ef14ad2},
        '{63, 64'hc67178f2e372532b}, '{79, 64'h6c44198c4a475817}
    };

    logic [63:0] msg   [16];
    logic [63:0] exp_w [80];

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic push_block(input mode_t m);
        bit          b64;
        int          n;
        logic [63:0] s0, s1;
        logic [31:0] a0, a1;
        exp_t        e;
        b64 = (m == SHA384) || (m == SHA512) || (m == SHA512_224) || (m == SHA512_256);
        n   = b64 ? 80 : 64;
        for (int t = 0; t < 16; t++) exp_w[t] = b64 ? msg[t] : {32'h0, msg[t][31:0]};
        for (int t = 16; t < n; t++) begin
            if (b64) begin
                s0 = r64(exp_w[t-15], 1) ^ r64(exp_w[t-15], 8) ^ (exp_w[t-15] >> 7);
                s1 = r64(exp_w[t-2], 19) ^ r64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end else begin
                a0 = r32(exp_w[t-15][31:0], 7) ^ r32(exp_w[t-15][31:0], 18) ^ (exp_w[t-15][31:0] >> 3);
                a1 = r32(exp_w[t-2][31:0], 17) ^ r32(exp_w[t-2][31:0], 19) ^ (exp_w[t-2][31:0] >> 10);
                exp_w[t] = {32'h0, a1 + exp_w[t-7][31:0] + a0 + exp_w[t-16][31:0]};
            end
        end
        for (int t = 0; t < n; t++) begin
            e.w = exp_w[t]; e.round = 7'(t); e.last = (t == n - 1); e.kchk = 0; e.k = '0;
            foreach (kref[j]) if (kref[j].idx == t) begin
                e.kchk = 1;
                e.k = b64 ? kref[j].k : {32'h0, kref[j].k[63:32]};
            end
            exp_q.push_back(e);
        end
    endtask

    // Output monitor: one line per beat, scoreboard compare.
    int          beats = 0;
    logic [63:0] cap_w [80];
    logic [63:0] cap_k [80];
    bit          prev_mid = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_mid = 0;
        end else begin
            if (prev_mid) check("run_gap", w_valid, 1'b1);
            if (w_valid) begin
                beats++;
                $display("beat t=%0d w=%h k=%h last=%0b", round, w, k, last);
                if (round < 80) begin cap_w[round] = w; cap_k[round] = k; end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got round %0d expected no beat", round);
                end else begin
                    e = exp_q.pop_front();
                    check("w", w, e.w);
                    check("round", round, e.round);
                    check("last", last, e.last);
                    if (e.kchk) check("k", k, e.k);
                end
            end else begin
                check("last_without_valid", last, 1'b0);
            end
            prev_mid = w_valid && !last && (round >= 7'd15);
        end
    end

    task automatic do_start(input mode_t m);
        mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("din_ready_after_start", din_ready, 1'b1);
    endtask

    task automatic do_load(input bit stall);
        for (int i = 0; i < 16; i++) begin
            if (stall) begin
                din_valid = 1'b0;
                @(posedge clk); #1;
                check("stall_no_beat", w_valid, 1'b0);
            end
            din_valid = 1'b1; din = msg[i];
            @(posedge clk); #1;
            check("load_beat", w_valid, 1'b1);
            check("load_round", round, 64'(i));
        end
        din_valid = 1'b0;
        check("din_ready_in_run", din_ready, 1'b0);
    endtask

    task automatic wait_last();
        for (int c = 0; c < 200; c++) begin
            if (last) break;
            @(posedge clk); #1;
        end
        check("last_seen", last, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_w_valid"}, w_valid, 1'b0);
        check({tag, "_w"}, w, 64'h0);
        check({tag, "_k"}, k, 64'h0);
        check({tag, "_round"}, round, 64'h0);
        check({tag, "_last"}, last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_din_ready"}, din_ready, 1'b0);
    endtask

    task automatic set_abc(input bit b64);
        foreach (msg[i]) msg[i] = '0;
        msg[0]  = b64 ? 64'h6162638000000000 : 64'h61626380;
        msg[15] = 64'h18;
    endtask

    typedef struct {
        mode_t       mode;
        bit          stall;
        logic [63:0] w0, w15, w16, w17, k0, klast;
        int          lastidx;
    } vec_t;
    vec_t vecs [4];

    initial begin
        vecs[0] = '{SHA256,     1'b0, 64'h61626380, 64'h18, 64'h61626380, 64'h000F0000,
                    64'h428A2F98, 64'hC67178F2, 63};
        vecs[1] = '{SHA512,     1'b0, 64'h6162638000000000, 64'h18, 64'h6162638000000000,
                    64'h00030000000000C0, 64'h428A2F98D728AE22, 64'h6C44198C4A475817, 79};
        vecs[2] = '{SHA256,     1'b1, 64'h61626380, 64'h18, 64'h61626380, 64'h000F0000,
                    64'h428A2F98, 64'hC67178F2, 63};
        vecs[3] = '{SHA512_256, 1'b1, 64'h6162638000000000, 64'h18, 64'h6162638000000000,
                    64'h00030000000000C0, 64'h428A2F98D728AE22, 64'h6C44198C4A475817, 79};

        rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0; mode = SHA256;
        repeat (3) @(posedge clk); #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven blocks (T1, T2, T3)
        foreach (vecs[r]) begin
            foreach (msg[i]) msg[i] = '0;
            msg[0] = vecs[r].w0; msg[15] = vecs[r].w15;
            beats = 0;
            push_block(vecs[r].mode);
            do_start(vecs[r].mode);
            do_load(vecs[r].stall);
            wait_last();
            @(posedge clk); #1;
            check("beat_count", 64'(beats), 64'(vecs[r].lastidx + 1));
            check("w16", cap_w[16], vecs[r].w16);
            check("w17", cap_w[17], vecs[r].w17);
            check("k0", cap_k[0], vecs[r].k0);
            check("k_last", cap_k[vecs[r].lastidx], vecs[r].klast);
            check("queue_drained", 64'(exp_q.size()), 64'h0);
            check("busy_after_block", busy, 1'b0);
        end

        // T4a: SHA-1 start is refused
        mode = SHA1; start = 1'b1;
        @(posedge clk); #1;
        check("sha1_busy", busy, 1'b0);
        check("sha1_din_ready", din_ready, 1'b0);
        @(posedge clk); #1;
        check("sha1_busy_2", busy, 1'b0);
        start = 1'b0;

        // T4b: start/mode changes during RUN are ignored
        set_abc(0);
        beats = 0;
        push_block(SHA256);
        do_start(SHA256);
        do_load(1'b0);
        repeat (10) @(posedge clk); #1;
        start = 1'b1; mode = SHA512;
        repeat (3) @(posedge clk); #1;
        start = 1'b0; mode = SHA256;
        wait_last();
        @(posedge clk); #1;
        check("midrun_beats", 64'(beats), 64'd64);
        check("midrun_queue", 64'(exp_q.size()), 64'h0);

        // T5: reset at t=30, then a fresh T1 block
        set_abc(0);
        push_block(SHA256);
        do_start(SHA256);
        do_load(1'b0);
        for (int c = 0; c < 100; c++) begin
            if (round == 7'd30) break;
            @(posedge clk); #1;
        end
        check("reached_t30", round, 64'd30);
        #1 rst = 1'b1;
        #1 check_idle_outputs("midblock_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("busy_after_reset", busy, 1'b0);
        beats = 0;
        push_block(SHA256);
        do_start(SHA256);
        do_load(1'b0);
        wait_last();
        @(posedge clk); #1;
        check("post_reset_beats", 64'(beats), 64'd64);
        check("post_reset_w17", cap_w[17], 64'h000F0000);
        check("post_reset_k63", cap_k[63], 64'hC67178F2);

        // T6: SHA-224 then SHA-384 back to back; din upper bits carry junk in the 224 block
        foreach (msg[i]) msg[i] = {$urandom, $urandom};
        beats = 0;
        push_block(SHA224);
        do_start(SHA224);
        do_load(1'b0);
        wait_last();
        foreach (msg[i]) msg[i] = {$urandom, $urandom};
        push_block(SHA384);
        do_start(SHA384);
        do_load(1'b0);
        wait_last();
        @(posedge clk); #1;
        check("b2b_beats", 64'(beats), 64'd144);
        check("b2b_queue", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
